// File: rtl/aes_ctr_seq_if.sv
// Signal bundle linking the register wrapper, the CTR sequencer
// and the AES core; clock and reset stay outside.
interface aes_ctr_seq_if #(
   parameter int NBLK_WIDTH = 16
);
   logic                  go_i;
   logic                  abort_i;
   logic [127:0]          cfg_iv_i;
   logic [NBLK_WIDTH-1:0] cfg_nblocks_i;
   logic                  din_valid_i;
   logic [127:0]          din_i;
   logic                  din_ready_o;
   logic                  core_start_o;
   logic [127:0]          core_block_o;
   logic [127:0]          core_out_i;
   logic                  core_valid_i;
   logic                  dout_valid_o;
   logic [127:0]          dout_o;
   logic                  dout_ready_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;
   logic [NBLK_WIDTH-1:0] blk_cnt_o;

   modport slave (
      input  go_i, abort_i, cfg_iv_i, cfg_nblocks_i,
      input  din_valid_i, din_i, core_out_i, core_valid_i,
      input  dout_ready_i,
      output din_ready_o, core_start_o, core_block_o,
      output dout_valid_o, dout_o, busy_o, done_o, err_o,
      output blk_cnt_o
   );

   modport master (
      output go_i, abort_i, cfg_iv_i, cfg_nblocks_i,
      output din_valid_i, din_i, core_out_i, core_valid_i,
      output dout_ready_i,
      input  din_ready_o, core_start_o, core_block_o,
      input  dout_valid_o, dout_o, busy_o, done_o, err_o,
      input  blk_cnt_o
   );
endinterface

// File: rtl/aes_ctr_seq.sv
// CTR-mode sequencer in front of the AES-192 core: feeds counter
// blocks to the core and XORs each core result with a data block.
module aes_ctr_seq #(
   parameter int CNT_WIDTH  = 32,
   parameter int NBLK_WIDTH = 16,
   parameter int TIMEOUT    = 64
) (
   input logic          clk_i,
   input logic          rst_ni,
   aes_ctr_seq_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [127:0]          r_ctr;
   logic [NBLK_WIDTH-1:0] r_nblk;
   logic [NBLK_WIDTH-1:0] r_blk_cnt;
   logic [127:0]          r_din;
   logic [127:0]          r_dout;
   logic                  r_err;
   logic                  r_arm;
   logic [TW-1:0]         r_tmo;

   logic                  w_go;
   logic                  w_load;
   logic                  w_accept;
   logic                  w_tmo_hit;
   logic                  w_emit_hs;
   logic [NBLK_WIDTH-1:0] w_blk_inc;
   logic [127:0]          w_ctr_inc;

   // Only the low counter field wraps; the nonce part is never touched.
   assign w_ctr_inc = {
      r_ctr[127:CNT_WIDTH],
      r_ctr[CNT_WIDTH-1:0] + CNT_WIDTH'(1)
   };
   assign w_blk_inc = r_blk_cnt + NBLK_WIDTH'(1);

   assign w_go = (r_state == S_IDLE)
               & bus.go_i & ~bus.abort_i;
   assign w_load = (r_state == S_LOAD)
                 & bus.din_valid_i & ~bus.abort_i;
   // A valid seen before one low cycle is a leftover of the last block.
   assign w_accept = (r_state == S_WAIT)
                   & r_arm & bus.core_valid_i
                   & ~bus.abort_i;
   assign w_tmo_hit = (r_state == S_WAIT)
                    & ~w_accept & ~bus.abort_i
                    & (r_tmo == TW'(TIMEOUT - 1));
   assign w_emit_hs = (r_state == S_EMIT)
                    & bus.dout_ready_i & ~bus.abort_i;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.go_i) begin
               w_next = (bus.cfg_nblocks_i == '0)
                      ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.din_valid_i) w_next = S_START;
         end
         S_START: w_next = S_WAIT;
         S_WAIT: begin
            if (w_accept) begin
               w_next = S_EMIT;
            end else if (w_tmo_hit) begin
               w_next = S_IDLE;
            end
         end
         S_EMIT: begin
            if (bus.dout_ready_i) begin
               w_next = (w_blk_inc == r_nblk)
                      ? S_DONE : S_LOAD;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (bus.abort_i) w_next = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ctr     <= '0;
         r_nblk    <= '0;
         r_blk_cnt <= '0;
         r_din     <= '0;
         r_dout    <= '0;
         r_err     <= 1'b0;
         r_arm     <= 1'b0;
         r_tmo     <= '0;
      end else begin
         if (w_go) begin
            r_ctr     <= bus.cfg_iv_i;
            r_nblk    <= bus.cfg_nblocks_i;
            r_blk_cnt <= '0;
            r_err     <= 1'b0;
         end
         if (w_load) r_din <= bus.din_i;
         if (r_state == S_START) begin
            r_arm <= 1'b0;
            r_tmo <= '0;
         end
         if (r_state == S_WAIT) begin
            if (!bus.core_valid_i) r_arm <= 1'b1;
            r_tmo <= r_tmo + TW'(1);
         end
         if (w_accept) r_dout <= bus.core_out_i ^ r_din;
         if (w_tmo_hit) r_err <= 1'b1;
         if (w_emit_hs) begin
            r_blk_cnt <= w_blk_inc;
            r_ctr     <= w_ctr_inc;
         end
      end
   end

   assign bus.din_ready_o  = (r_state == S_LOAD);
   assign bus.core_start_o = (r_state == S_START);
   assign bus.core_block_o = r_ctr;
   assign bus.dout_valid_o = (r_state == S_EMIT);
   assign bus.dout_o       = r_dout;
   assign bus.busy_o       = (r_state != S_IDLE);
   assign bus.done_o       = (r_state == S_DONE);
   assign bus.err_o        = r_err;
   assign bus.blk_cnt_o    = r_blk_cnt;
endmodule

// File: tb/tb_aes_ctr_seq.sv
// Randomised scoreboard bench for aes_ctr_seq with a stub AES core
// that returns block ^ A5..A5 after a programmable delay.
module tb_aes_ctr_seq;
   localparam int NW = 16;
   localparam logic [127:0] K_A5 = {16{8'hA5}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_ctr_seq_if #(.NBLK_WIDTH(NW)) bus ();

   aes_ctr_seq #(
      .CNT_WIDTH (32),
      .NBLK_WIDTH(NW),
      .TIMEOUT   (64)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   int n_start = 0;
   int n_done = 0;
   int n_dinrdy = 0;
   logic [127:0] q_ctr[$];
   logic [127:0] q_dout[$];

   // 0: one-cycle pulse, 1: valid stuck high, 2: level valid
   int stub_mode = 0;
   int stub_fix = 0;
   int s_age = 100000;
   int s_lat = 0;
   logic [127:0] s_blk = '0;
   bit stall_req = 1'b0;
   int stall_n = 0;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stub AES core.
   always @(negedge clk) begin
      if (bus.core_start_o) begin
         s_blk = bus.core_block_o;
         s_age = 0;
         if (stub_fix > 0) s_lat = stub_fix;
         else if (stub_mode == 2)
            s_lat = int'($urandom_range(4, 9));
         else
            s_lat = int'($urandom_range(2, 8));
      end else if (s_age < 100000) begin
         s_age++;
      end
      if (stub_mode == 1)
         bus.core_valid_i = 1'b1;
      else if (stub_mode == 0)
         bus.core_valid_i = (s_age == s_lat);
      else if (s_age > 1)
         bus.core_valid_i = (s_age >= s_lat);
      if (s_age == s_lat) bus.core_out_i = s_blk ^ K_A5;
   end

   // Downstream sink with random back-pressure.
   always @(posedge clk) begin
      #1;
      if (stall_req && bus.dout_valid_o) begin
         bus.dout_ready_i = 1'b0;
         stall_n++;
         if (stall_n >= 10) stall_req = 1'b0;
      end else begin
         bus.dout_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor / scoreboard.
   bit prev_stall = 1'b0;
   logic [127:0] prev_dout;
   logic [127:0] prev_blk;
   logic [NW-1:0] prev_cnt;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.core_start_o) begin
            n_start++;
            chk("start_expected", 128'(q_ctr.size() > 0), 1);
            if (q_ctr.size() > 0)
               chk("core_block", bus.core_block_o,
                   q_ctr.pop_front());
         end
         if (prev_stall) begin
            chk("dout_valid_hold", 128'(bus.dout_valid_o), 1);
            chk("dout_hold", bus.dout_o, prev_dout);
            chk("ctr_hold", bus.core_block_o, prev_blk);
            chk("cnt_hold", 128'(bus.blk_cnt_o),
                128'(prev_cnt));
         end
         if (bus.dout_valid_o && bus.dout_ready_i) begin
            chk("dout_expected", 128'(q_dout.size() > 0), 1);
            if (q_dout.size() > 0)
               chk("dout", bus.dout_o, q_dout.pop_front());
         end
         if (bus.done_o) n_done++;
         if (bus.din_ready_o) n_dinrdy++;
         prev_stall = bus.dout_valid_o & ~bus.dout_ready_i;
         prev_dout = bus.dout_o;
         prev_blk = bus.core_block_o;
         prev_cnt = bus.blk_cnt_o;
      end
   end

   task automatic wait_rdy(output bit ok);
      int c;
      c = 0;
      ok = 1'b0;
      while (c < 300) begin
         @(negedge clk);
         c++;
         if (bus.din_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      chk("din_ready_wait", 128'(ok), 1);
   endtask

   task automatic run_job(input logic [127:0] iv,
                          input int nblk,
                          input int abort_at,
                          input bit to_mode,
                          input bit use_fix,
                          input logic [127:0] dfix);
      int done0;
      int c;
      bit ok;
      logic [127:0] d;
      logic [127:0] cb;
      logic [31:0] lo;
      bus.cfg_iv_i = iv;
      bus.cfg_nblocks_i = NW'(nblk);
      bus.go_i = 1'b1;
      tick();
      bus.go_i = 1'b0;
      bus.cfg_iv_i = rand128();
      bus.cfg_nblocks_i = NW'($urandom);
      done0 = n_done;
      @(negedge clk);
      chk("err_clear_on_go", 128'(bus.err_o), 0);
      chk("cnt_clear_on_go", 128'(bus.blk_cnt_o), 0);
      for (int i = 0; i < nblk; i++) begin
         wait_rdy(ok);
         if (!ok) return;
         if (i == abort_at) begin
            bus.abort_i = 1'b1;
            tick();
            bus.abort_i = 1'b0;
            @(negedge clk);
            chk("abort_busy", 128'(bus.busy_o), 0);
            chk("abort_rdy", 128'(bus.din_ready_o), 0);
            chk("abort_cnt", 128'(bus.blk_cnt_o), 128'(i));
            chk("abort_err", 128'(bus.err_o), 0);
            chk("abort_no_done", 128'(n_done), 128'(done0));
            return;
         end
         d = use_fix ? dfix : rand128();
         lo = iv[31:0] + 32'(i);
         cb = {iv[127:32], lo};
         q_ctr.push_back(cb);
         if (!to_mode) q_dout.push_back(cb ^ K_A5 ^ d);
         bus.din_i = d;
         bus.din_valid_i = 1'b1;
         bus.go_i = 1'($urandom_range(0, 1));
         tick();
         bus.din_valid_i = 1'b0;
         bus.go_i = 1'b0;
         if (to_mode) begin
            c = 0;
            while (c < 200 && !bus.err_o) begin
               @(negedge clk);
               c++;
            end
            chk("timeout_cycles", 128'(c), 66);
            chk("timeout_busy", 128'(bus.busy_o), 0);
            chk("timeout_no_done", 128'(n_done),
                128'(done0));
            return;
         end
      end
      c = 0;
      while (c < 400 && !bus.done_o) begin
         @(negedge clk);
         c++;
      end
      chk("done_seen", 128'(bus.done_o), 1);
      chk("done_cnt", 128'(bus.blk_cnt_o), 128'(nblk));
      chk("done_err", 128'(bus.err_o), 0);
      @(negedge clk);
      chk("done_pulse", 128'(bus.done_o), 0);
      chk("idle_busy", 128'(bus.busy_o), 0);
      chk("cnt_held", 128'(bus.blk_cnt_o), 128'(nblk));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int r0;
      logic [127:0] iv;
      bus.go_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.cfg_iv_i = '0;
      bus.cfg_nblocks_i = '0;
      bus.din_valid_i = 1'b0;
      bus.din_i = '0;
      bus.core_out_i = '0;
      bus.core_valid_i = 1'b0;
      bus.dout_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 128'(bus.busy_o), 0);
      chk("rst_done", 128'(bus.done_o), 0);
      chk("rst_err", 128'(bus.err_o), 0);
      chk("rst_rdy", 128'(bus.din_ready_o), 0);
      chk("rst_start", 128'(bus.core_start_o), 0);
      chk("rst_dvalid", 128'(bus.dout_valid_o), 0);
      chk("rst_dout", bus.dout_o, 0);
      chk("rst_block", bus.core_block_o, 0);
      chk("rst_cnt", 128'(bus.blk_cnt_o), 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      stub_fix = 5;
      run_job('0, 1, -1, 1'b0, 1'b1, {16{8'h0F}});
      stub_fix = 0;

      iv = {96'h0123456789ABCDEF01234567, 32'hFFFFFFFF};
      run_job(iv, 2, -1, 1'b0, 1'b0, '0);

      s0 = n_start;
      r0 = n_dinrdy;
      bus.cfg_nblocks_i = '0;
      bus.go_i = 1'b1;
      tick();
      bus.go_i = 1'b0;
      @(negedge clk);
      chk("zero_done", 128'(bus.done_o), 1);
      @(negedge clk);
      chk("zero_done_end", 128'(bus.done_o), 0);
      chk("zero_busy", 128'(bus.busy_o), 0);
      chk("zero_no_start", 128'(n_start), 128'(s0));
      chk("zero_no_rdy", 128'(n_dinrdy), 128'(r0));

      bus.cfg_nblocks_i = NW'(3);
      bus.go_i = 1'b1;
      bus.abort_i = 1'b1;
      tick();
      bus.go_i = 1'b0;
      bus.abort_i = 1'b0;
      @(negedge clk);
      chk("abort_go_busy", 128'(bus.busy_o), 0);

      for (int j = 0; j < 8; j++) begin
         stub_mode = int'($urandom_range(0, 1)) * 2;
         iv = rand128();
         if (j % 3 == 0) iv[31:0] = 32'hFFFF_FFFE;
         run_job(iv, int'($urandom_range(1, 5)), -1,
                 1'b0, 1'b0, '0);
      end
      stub_mode = 0;

      stall_n = 0;
      stall_req = 1'b1;
      run_job(rand128(), 1, -1, 1'b0, 1'b0, '0);
      chk("stall_len", 128'(stall_n), 10);

      stub_mode = 1;
      run_job(rand128(), 3, -1, 1'b1, 1'b0, '0);
      chk("err_sticky", 128'(bus.err_o), 1);
      stub_mode = 0;
      repeat (3) tick();

      run_job(rand128(), 4, 2, 1'b0, 1'b0, '0);
      run_job(rand128(), 2, -1, 1'b0, 1'b0, '0);

      repeat (5) tick();
      chk("ctr_queue_empty", 128'(q_ctr.size()), 0);
      chk("dout_queue_empty", 128'(q_dout.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
